// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL reset supervisor.
// The state encoding and count defaults are used by the top and its bench.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
  localparam int unsigned DEF_LOCK_STABLE    = 1024;
  localparam int unsigned DEF_RELEASE_DELAY  = 256;
  localparam int unsigned DEF_CNT_W          = 17;
  localparam int unsigned DEF_RETRY_W        = 4;

  function automatic bit cnt_w_ok(
    input int unsigned w,
    input int unsigned a,
    input int unsigned b,
    input int unsigned c,
    input int unsigned d
  );
    longint unsigned m;
    m = longint'(a);
    if (longint'(b) > m) m = longint'(b);
    if (longint'(c) > m) m = longint'(c);
    if (longint'(d) > m) m = longint'(d);
    return (w < 63) && (m >= 1) && ((m - 1) < (64'd1 << w));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_supervisor.sv
// Sequences PLL reset, qualifies lock and gates the system reset.
// Runs on the free-running reference clock only.
module pll_reset_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int unsigned RELEASE_DELAY  = DEF_RELEASE_DELAY,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned RETRY_W        = DEF_RETRY_W
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  if (!cnt_w_ok(CNT_W, PLL_RST_CYCLES, LOCK_TIMEOUT,
                LOCK_STABLE, RELEASE_DELAY)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured counts");
  end

  localparam logic [CNT_W-1:0] PR_T = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_T = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_T = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] RL_T = CNT_W'(RELEASE_DELAY - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;
  logic             inc_retry;
  logic             set_lost;
  logic             pll_rst_d;
  logic             sys_rst_d;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= PLL_RESET;
      cnt       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state <= nxt;
      // RUN parks the counter at zero
      if (nxt != state || state == RUN)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (inc_retry && retry_cnt != '1)
        retry_cnt <= retry_cnt + 1'b1;
      if (set_lost)
        lock_lost <= 1'b1;
      pll_rst <= pll_rst_d;
      sys_rst <= sys_rst_d;
      ready   <= ~sys_rst_d;
    end
  end

  always_comb begin
    nxt       = state;
    inc_retry = 1'b0;
    set_lost  = 1'b0;
    unique case (state)
      PLL_RESET: begin
        if (cnt == PR_T) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          nxt = STABILIZE;
        end else if (cnt == TO_T) begin
          nxt       = PLL_RESET;
          inc_retry = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s)        nxt = WAIT_LOCK;
        else if (cnt == ST_T) nxt = RELEASE;
      end
      RELEASE: begin
        if (!locked_s) begin
          nxt      = PLL_RESET;
          set_lost = 1'b1;
        end else if (cnt == RL_T) begin
          nxt = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          nxt      = PLL_RESET;
          set_lost = 1'b1;
        end
      end
      default: nxt = PLL_RESET;
    endcase
  end

  always_comb begin
    pll_rst_d = (nxt == PLL_RESET);
    sys_rst_d = (nxt != RUN);
  end

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed bench for pll_reset_supervisor with shortened counts.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_pll_reset_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] retry_cnt;
  logic       lock_lost;

  int n_chk = 0;
  int n_fail = 0;

  pll_reset_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .LOCK_STABLE    (8),
    .RELEASE_DELAY  (4),
    .CNT_W          (5),
    .RETRY_W        (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  always #5 refclk = ~refclk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Leaves the DUT one edge past the last reset edge is pending.
  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL rst_pll_rst: got %b want 1", pll_rst); end
    n_chk++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL rst_sys_rst: got %b want 1", sys_rst); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_chk++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_retry: got %0d want 0", retry_cnt); end
    n_chk++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL rst_lost: got %b want 0", lock_lost); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_chk++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL pulse_hi c%0d: got %b want 1", i, pll_rst); end
    end
    tick();
    n_chk++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL pulse_end: got %b want 0", pll_rst); end
    n_chk++; if ({sys_rst, ready} !== 2'b10) begin n_fail++; $display("FAIL pulse_sys: got %b%b want 10", sys_rst, ready); end
  endtask

  task automatic test_lock_latency();
    do_reset();
    tick(4);
    tick(5);
    pll_locked = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      n_chk++; if ({pll_rst, sys_rst, ready} !== 3'b010) begin n_fail++; $display("FAIL lat_pre c%0d: got %b%b%b want 010", i, pll_rst, sys_rst, ready); end
    end
    tick();
    n_chk++; if ({pll_rst, sys_rst, ready} !== 3'b001) begin n_fail++; $display("FAIL lat_release: got %b%b%b want 001", pll_rst, sys_rst, ready); end
  endtask

  task automatic test_glitch();
    do_reset();
    tick(4);
    pll_locked = 1'b1;
    tick(3);
    tick(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick(6);
    n_chk++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_nominal: got %b want 1", sys_rst); end
    tick(8);
    n_chk++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_early: got %b want 1", sys_rst); end
    tick();
    n_chk++; if ({sys_rst, ready} !== 2'b01) begin n_fail++; $display("FAIL glitch_release: got %b%b want 01", sys_rst, ready); end
    n_chk++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL glitch_retry: got %0d want 0", retry_cnt); end
    n_chk++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL glitch_lost: got %b want 0", lock_lost); end
  endtask

  task automatic test_loss_of_lock();
    pll_locked = 1'b0;
    tick(2);
    n_chk++; if ({pll_rst, sys_rst} !== 2'b00) begin n_fail++; $display("FAIL loss_early: got %b%b want 00", pll_rst, sys_rst); end
    tick();
    n_chk++; if ({pll_rst, sys_rst, ready} !== 3'b110) begin n_fail++; $display("FAIL loss_reassert: got %b%b%b want 110", pll_rst, sys_rst, ready); end
    n_chk++; if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL loss_flag: got %b want 1", lock_lost); end
    pll_locked = 1'b1;
    tick(16);
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b want 0", ready); end
    tick();
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL relock_ready: got %b want 1", ready); end
    n_chk++; if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL relock_sticky: got %b want 1", lock_lost); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL lost_clear: got %b want 0", lock_lost); end
  endtask

  task automatic test_timeout();
    logic [1:0] exp;
    do_reset();
    tick(4);
    for (int k = 1; k <= 4; k++) begin
      exp = (k > 3) ? 2'd3 : 2'(k);
      tick(19);
      n_chk++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL to_wait k%0d: got %b want 0", k, pll_rst); end
      tick();
      n_chk++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL to_pulse k%0d: got %b want 1", k, pll_rst); end
      n_chk++; if (retry_cnt !== exp) begin n_fail++; $display("FAIL to_retry k%0d: got %0d want %0d", k, retry_cnt, exp); end
      tick(3);
      n_chk++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL to_hold k%0d: got %b want 1", k, pll_rst); end
      tick();
      n_chk++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL to_end k%0d: got %b want 0", k, pll_rst); end
    end
  endtask

  task automatic test_reset_mid();
    pll_locked = 1'b1;
    tick(3);
    tick(8);
    tick(2);
    n_chk++; if ({pll_rst, sys_rst, retry_cnt} !== 4'b0111) begin n_fail++; $display("FAIL mid_pre: got %b%b%0d want 01 3", pll_rst, sys_rst, retry_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({pll_rst, sys_rst, ready} !== 3'b110) begin n_fail++; $display("FAIL mid_rst: got %b%b%b want 110", pll_rst, sys_rst, ready); end
    n_chk++; if ({retry_cnt, lock_lost} !== 3'b000) begin n_fail++; $display("FAIL mid_clear: got %0d %b want 0 0", retry_cnt, lock_lost); end
    tick(3);
    n_chk++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL mid_pulse: got %b want 1", pll_rst); end
    tick();
    n_chk++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL mid_pulse_end: got %b want 0", pll_rst); end
    tick(12);
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_early: got %b want 0", ready); end
    tick();
    n_chk++; if ({sys_rst, ready} !== 2'b01) begin n_fail++; $display("FAIL mid_run: got %b%b want 01", sys_rst, ready); end
  endtask

  initial begin
    test_reset();
    test_lock_latency();
    test_glitch();
    test_loss_of_lock();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
